// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment types, dark constant and hex-to-segment table
package seg7_pkg;

  // Active-low segment vector ordered {g,f,e,d,c,b,a}
  typedef logic [6:0] seg7_t;

  // All segments off
  localparam seg7_t SEG_OFF = 7'b1111111;

  // Standard hex glyphs, lower-case b and d so they differ from 8 and 0
  function automatic seg7_t hex_to_seg(input logic [3:0] code);
    seg7_t seg;
    case (code)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational 4-bit hex code to active-low segment decode
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output seg7_t      seg
);

  assign seg = hex_to_seg(code);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit seven-segment scanner with blink; optional LEADING_ZERO_BLANK_EN
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_SCANS  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  enable,
  output seg7_t                 seg7,
  output logic [N_DIGITS-1:0]   dig,
  output logic                  scan_tick
);

  localparam int DW = $clog2(DWELL_CYCLES);
  localparam int IW = $clog2(N_DIGITS);
  localparam int SW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  logic [DW-1:0] dwell_cnt;
  logic [IW-1:0] index;
  logic [SW-1:0] scan_cnt;
  logic          blink_phase;

  logic          dwell_last;
  logic          index_zero;
  logic          scan_wrap;
  logic [3:0]    code;
  seg7_t         dec_seg;
  logic          lit;
  logic          hide;
  seg7_t         seg_next;
  logic [N_DIGITS-1:0] dig_next;

  assign dwell_last = (dwell_cnt == DW'(DWELL_CYCLES - 1));
  assign index_zero = (index == '0);
  assign scan_wrap  = dwell_last && index_zero;

  // Digits are read straight off the bus so a mid-dwell change shows next cycle
  assign code = digits[4*index +: 4];

  hex_to_seg7 u_dec (
    .code (code),
    .seg  (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_blank;
  logic                lz_run;

  // Walk from the leftmost digit down; stay blanking until a nonzero code; digit 0 always shown
  always_comb begin
    lz_blank = '0;
    lz_run   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (digits[4*i +: 4] != 4'h0) lz_run = 1'b0;
      lz_blank[i] = lz_run;
    end
  end

  assign hide = (blink_mask[index] && !blink_phase) || lz_blank[index];
`else
  assign hide = blink_mask[index] && !blink_phase;
`endif

  // Anodes stay off in the anti-ghost window at the start of each dwell and while disabled
  assign lit      = enable && (int'(dwell_cnt) >= BLANK_CYCLES);
  assign dig_next = lit ? ~(N_DIGITS'(1) << index) : '1;
  assign seg_next = (lit && !hide) ? dec_seg : SEG_OFF;

  // Scan counters: dwell, digit index (left to right), and full-scan count driving the blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_cnt   <= '0;
      index       <= IW'(N_DIGITS - 1);
      scan_cnt    <= '0;
      blink_phase <= 1'b1;
    end else begin
      if (dwell_last) begin
        dwell_cnt <= '0;
        index     <= index_zero ? IW'(N_DIGITS - 1) : index - IW'(1);
      end else begin
        dwell_cnt <= dwell_cnt + DW'(1);
      end
      if (scan_wrap) begin
        if (scan_cnt == SW'(BLINK_SCANS - 1)) begin
          scan_cnt    <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          scan_cnt <= scan_cnt + SW'(1);
        end
      end
    end
  end

  // Registered pin drivers, one cycle behind the counter state they reflect
  always_ff @(posedge clk) begin
    if (rst) begin
      seg7      <= SEG_OFF;
      dig       <= '1;
      scan_tick <= 1'b0;
    end else begin
      seg7      <= seg_next;
      dig       <= dig_next;
      scan_tick <= scan_wrap;
    end
  end

endmodule
